intr_ctrl: RTL and testbench
============================

INTR_CTRL -- requirements
Module: intr_ctrl

Interface
REQ-001 The block SHALL provide parameter N_SRC, default 8, meaning the number of interrupt sources (1..16).
REQ-002 The block SHALL provide parameter VEC_RST, default 32'h0000_0200, meaning the reset value of VEC_BASE.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 The block SHALL have these ports:
- sys_clk  in  1  clock, rising edge active
- reset_n  in  1  asynchronous active-low reset
- irq  in  N_SRC  interrupt sources, synchronous to sys_clk, rising-edge sensitive
- INT_ACK  in  1  acknowledge from MIPS control unit, level held at least 1 cycle
- cfg_wr  in  1  config write strobe, one cycle
- cfg_addr  in  2  config register select
- cfg_wdata  in  32  config write data
- cfg_rdata  out  32  config read data, combinational from cfg_addr
- INTR  out  1  interrupt request to MIPS control unit
- vector  out  32  ISR address for the frozen request
- irq_id  out  4  index of the frozen request

Function
REQ-005 Register map SHALL be: 0 MASK (RW, bit i = 1 enables source i); 1 PENDING (read, write-1-to-clear); 2 VEC_BASE (RW); 3 STATUS (read {state, irq_id}; any write = EOI).
REQ-006 The block SHALL register irq each cycle; a source is detected when current irq[i]=1 and the previous sample was 0, and PENDING[i] is set at that same edge.
REQ-007 Level-high irq without a new rising edge SHALL NOT re-set PENDING.
REQ-008 The FSM SHALL have states IDLE, REQ and SERVICE.
REQ-009 IDLE -> REQ: on an edge where (PENDING & MASK) != 0. At that edge irq_id SHALL latch the lowest set index of (PENDING & MASK), vector SHALL latch VEC_BASE + 4*irq_id (32-bit wrap), and INTR SHALL be 1.
REQ-010 In REQ, irq_id and vector SHALL stay frozen; MASK or PENDING writes SHALL NOT retract INTR.
REQ-011 REQ -> SERVICE: on the first edge where INT_ACK = 1 and the previous INT_ACK sample was 0. At that edge INTR SHALL go 0 and PENDING[irq_id] SHALL clear.
REQ-012 SERVICE -> IDLE: on a cfg_wr to address 3. EOI SHALL be ignored in IDLE and REQ.
REQ-013 INT_ACK edges outside REQ SHALL be ignored.
REQ-014 Minimum latency from an irq rising edge (sampled at edge k) to INTR=1 SHALL be edge k+1.
REQ-015 A pending-set event and a clear (W1C or ack) on the same bit in the same cycle SHALL leave the bit set.
REQ-016 Sources detected while in REQ or SERVICE SHALL accumulate in PENDING; there is no nesting or preemption.
REQ-017 Writes to VEC_BASE SHALL take effect for the next IDLE -> REQ transition only.
REQ-018 Bits of MASK and PENDING at or above N_SRC SHALL read 0 and ignore writes.

Reset
REQ-019 While reset_n = 0, the block SHALL force: state IDLE, INTR 0, MASK 0, PENDING 0, VEC_BASE VEC_RST, irq_id 0, vector 0, and both irq and INT_ACK history registers 0.
REQ-020 Reset asserted mid-REQ or mid-SERVICE SHALL drop INTR immediately (asynchronously) and discard all pending state.
REQ-021 The first edge after reset_n deasserts SHALL perform normal edge detection against the zeroed history.

Structure
REQ-022 A shared package intr_pkg SHALL hold the state encoding, the register address constants (MASK, PENDING, VEC_BASE, STATUS) and the default VEC_RST.
REQ-023 Priority selection SHALL be a sub-module intr_prio_enc (N_SRC-wide vector in, valid and 4-bit index out, lowest index wins).

Verification
REQ-024 Bench SHALL cover: MASK=0x01, irq[0] rises -> INTR=1 on the next edge, vector=0x200, irq_id=0.
REQ-025 Bench SHALL cover: MASK=0xFF, irq[5] and irq[2] rise together -> irq_id=2 and vector=0x208; after ack and EOI -> INTR re-asserts with irq_id=5 and vector=0x214.
REQ-026 Bench SHALL cover: INT_ACK pulse in REQ -> INTR=0 and PENDING[id]=0 at the same edge; STATUS shows SERVICE until the write to address 3.
REQ-027 Bench SHALL cover: irq[3] rises with MASK=0 -> no INTR and PENDING=0x08; then writing MASK=0x08 -> INTR on the next edge.
REQ-028 Bench SHALL cover: W1C of PENDING bit 1 in the same cycle that irq[1] rises -> PENDING[1] stays 1.
REQ-029 Bench SHALL cover: reset_n pulled low while in REQ -> INTR=0 without a clock edge; after release, all registers read their reset values.

Source files
------------

// File: rtl/intr_pkg.sv
// Shared definitions for the interrupt controller: FSM encoding, register map, reset vector base.
// Latency: none, because the package holds only types and constants. Backpressure: none.
package intr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    localparam logic [1:0] ADDR_MASK     = 2'd0;
    localparam logic [1:0] ADDR_PENDING  = 2'd1;
    localparam logic [1:0] ADDR_VEC_BASE = 2'd2;
    localparam logic [1:0] ADDR_STATUS   = 2'd3;

    localparam logic [31:0] VEC_RST_DEFAULT = 32'h0000_0200;

endpackage

// File: rtl/intr_prio_enc.sv
// Fixed-priority encoder: the lowest set index wins, and valid is set when any bit is set.
// Latency: combinational. Backpressure: none.
module intr_prio_enc #(
    parameter int N = 8
) (
    input  logic [N-1:0] i_vec,
    output logic         o_vld,
    output logic [3:0]   o_idx
);

    always_comb begin
        o_vld = |i_vec;
        o_idx = 4'd0;
        // Scan downward so the lowest set index is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (i_vec[i]) o_idx = 4'(i);
        end
    end

endmodule

// File: rtl/intr_ctrl.sv
// Edge-triggered interrupt controller with a mask, W1C pending register and IDLE/REQ/SERVICE handshake.
// Latency: INTR rises 1 edge after PENDING&MASK; the request stays frozen until an ACK edge, and the next request waits for EOI.
module intr_ctrl
    import intr_pkg::*;
#(
    parameter int          N_SRC   = 8,
    parameter logic [31:0] VEC_RST = VEC_RST_DEFAULT
) (
    input  logic             sys_clk,
    input  logic             reset_n,
    input  logic [N_SRC-1:0] irq,
    input  logic             INT_ACK,
    input  logic             cfg_wr,
    input  logic [1:0]       cfg_addr,
    input  logic [31:0]      cfg_wdata,
    output logic [31:0]      cfg_rdata,
    output logic             INTR,
    output logic [31:0]      vector,
    output logic [3:0]       irq_id
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [N_SRC-1:0]   r_irq_q;
    logic               r_ack_q;
    logic [N_SRC-1:0]   r_mask;
    logic [N_SRC-1:0]   r_pend;
    logic [31:0]        r_vec_base;
    logic [31:0]        r_vector;
    logic [3:0]         r_irq_id;

    logic [N_SRC-1:0]   w_irq_rise;
    logic               w_ack_rise;
    logic [N_SRC-1:0]   w_masked;
    logic               w_sel_vld;
    logic [3:0]         w_sel_idx;
    logic               w_wr_mask;
    logic               w_wr_pend;
    logic               w_wr_base;
    logic               w_wr_status;
    logic               w_take;
    logic               w_ack_take;
    logic [N_SRC-1:0]   w_clr;
    logic [N_SRC-1:0]   w_pend_nxt;

    assign w_irq_rise  = irq & ~r_irq_q;
    assign w_ack_rise  = INT_ACK & ~r_ack_q;
    assign w_masked    = r_pend & r_mask;

    assign w_wr_mask   = cfg_wr && (cfg_addr == ADDR_MASK);
    assign w_wr_pend   = cfg_wr && (cfg_addr == ADDR_PENDING);
    assign w_wr_base   = cfg_wr && (cfg_addr == ADDR_VEC_BASE);
    assign w_wr_status = cfg_wr && (cfg_addr == ADDR_STATUS);

    intr_prio_enc #(
        .N (N_SRC)
    ) u_prio (
        .i_vec (w_masked),
        .o_vld (w_sel_vld),
        .o_idx (w_sel_idx)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (w_sel_vld)   w_state_nxt = ST_REQ;
            ST_REQ:     if (w_ack_rise)  w_state_nxt = ST_SERVICE;
            ST_SERVICE: if (w_wr_status) w_state_nxt = ST_IDLE;
            default:                     w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_take     = (r_state == ST_IDLE) && (w_state_nxt == ST_REQ);
    assign w_ack_take = (r_state == ST_REQ) && (w_state_nxt == ST_SERVICE);

    // A fresh rising edge wins over a same-cycle clear on the same bit.
    always_comb begin
        for (int i = 0; i < N_SRC; i++) begin
            w_clr[i] = (w_wr_pend && cfg_wdata[i]) || (w_ack_take && (r_irq_id == 4'(i)));
        end
        w_pend_nxt = (r_pend & ~w_clr) | w_irq_rise;
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_irq_q    <= '0;
            r_ack_q    <= 1'b0;
            r_mask     <= '0;
            r_pend     <= '0;
            r_vec_base <= VEC_RST;
            r_vector   <= 32'd0;
            r_irq_id   <= 4'd0;
        end else begin
            r_irq_q <= irq;
            r_ack_q <= INT_ACK;
            r_pend  <= w_pend_nxt;
            if (w_wr_mask) r_mask     <= cfg_wdata[N_SRC-1:0];
            if (w_wr_base) r_vec_base <= cfg_wdata;
            // The current base is sampled, so a same-edge base write only affects later requests.
            if (w_take) begin
                r_irq_id <= w_sel_idx;
                r_vector <= r_vec_base + {26'd0, w_sel_idx, 2'b00};
            end
        end
    end

    always_comb begin
        cfg_rdata = 32'd0;
        case (cfg_addr)
            ADDR_MASK:     cfg_rdata[N_SRC-1:0] = r_mask;
            ADDR_PENDING:  cfg_rdata[N_SRC-1:0] = r_pend;
            ADDR_VEC_BASE: cfg_rdata            = r_vec_base;
            ADDR_STATUS:   cfg_rdata[5:0]       = {r_state, r_irq_id};
            default:       cfg_rdata            = 32'd0;
        endcase
    end

    // Decoded straight from the state register, so reset drops it without a clock edge.
    assign INTR   = (r_state == ST_REQ);
    assign vector = r_vector;
    assign irq_id = r_irq_id;

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed table, reset corner sequence and randomized run against a behavioural model of intr_ctrl.
module tb_intr_ctrl;

    logic        sys_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  irq = 8'h00;
    logic        INT_ACK = 1'b0;
    logic        cfg_wr = 1'b0;
    logic [1:0]  cfg_addr = 2'd0;
    logic [31:0] cfg_wdata = 32'd0;
    logic [31:0] cfg_rdata;
    logic        INTR;
    logic [31:0] vector;
    logic [3:0]  irq_id;

    intr_ctrl #(
        .N_SRC   (8),
        .VEC_RST (32'h0000_0200)
    ) dut (
        .sys_clk   (sys_clk),
        .reset_n   (reset_n),
        .irq       (irq),
        .INT_ACK   (INT_ACK),
        .cfg_wr    (cfg_wr),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_rdata (cfg_rdata),
        .INTR      (INTR),
        .vector    (vector),
        .irq_id    (irq_id)
    );

    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0]  irq;
        logic        ack;
        logic        wr;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic        e_intr;
        logic [3:0]  e_id;
        logic [31:0] e_vec;
        logic [31:0] e_rd;
    } vec_t;

    vec_t tbl[$];

    // Behavioural model: per-source flags and plain integers.
    bit        m_pend[8];
    bit        m_mask[8];
    bit        m_prev_irq[8];
    bit        m_prev_ack;
    bit        m_intr;
    bit        m_serv;
    int        m_id;
    bit [31:0] m_base;
    bit [31:0] m_vec;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic add(input int ir, input int ak, input int wr, input int ad, input int wd,
                       input int ei, input int eid, input int ev, input int erd);
        vec_t v;
        v.irq = 8'(ir);  v.ack = 1'(ak);  v.wr = 1'(wr);  v.addr = 2'(ad);  v.wdata = 32'(wd);
        v.e_intr = 1'(ei);  v.e_id = 4'(eid);  v.e_vec = 32'(ev);  v.e_rd = 32'(erd);
        tbl.push_back(v);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_pend[i] = 1'b0;  m_mask[i] = 1'b0;  m_prev_irq[i] = 1'b0;
        end
        m_prev_ack = 1'b0;  m_intr = 1'b0;  m_serv = 1'b0;
        m_id = 0;  m_base = 32'h200;  m_vec = 32'd0;
    endtask

    task automatic model_edge();
        int        sel;
        bit        ack_ev;
        bit        eoi;
        bit        clr;
        bit        rise;
        bit [31:0] wd;
        sel = -1;
        wd  = cfg_wdata;
        if (!m_intr && !m_serv) begin
            for (int i = 0; i < 8; i++) if (sel < 0 && m_pend[i] && m_mask[i]) sel = i;
        end
        ack_ev = m_intr && INT_ACK && !m_prev_ack;
        eoi    = m_serv && cfg_wr && (cfg_addr == 2'd3);
        for (int i = 0; i < 8; i++) begin
            clr  = (cfg_wr && cfg_addr == 2'd1 && wd[i]) || (ack_ev && i == m_id);
            rise = irq[i] && !m_prev_irq[i];
            m_pend[i] = (m_pend[i] && !clr) || rise;
            if (cfg_wr && cfg_addr == 2'd0) m_mask[i] = wd[i];
            m_prev_irq[i] = irq[i];
        end
        if (sel >= 0) begin
            m_intr = 1'b1;
            m_id   = sel;
            m_vec  = m_base + 32'(sel * 4);
        end
        if (ack_ev) begin
            m_intr = 1'b0;
            m_serv = 1'b1;
        end
        if (eoi) m_serv = 1'b0;
        if (cfg_wr && cfg_addr == 2'd2) m_base = wd;
        m_prev_ack = INT_ACK;
    endtask

    function automatic logic [31:0] m_read(input logic [1:0] a);
        logic [31:0] r;
        r = 32'd0;
        case (a)
            2'd0: for (int i = 0; i < 8; i++) r = r + (32'(m_mask[i]) << i);
            2'd1: for (int i = 0; i < 8; i++) r = r + (32'(m_pend[i]) << i);
            2'd2: r = m_base;
            default: r = (m_intr ? 32'd16 : (m_serv ? 32'd32 : 32'd0)) + 32'(m_id);
        endcase
        return r;
    endfunction

    task automatic check_reset_regs(input string tag);
        logic [31:0] exp_rd[4];
        exp_rd[0] = 32'd0;  exp_rd[1] = 32'd0;  exp_rd[2] = 32'h200;  exp_rd[3] = 32'd0;
        chk({tag, " INTR"},   32'(INTR), 32'd0);
        chk({tag, " irq_id"}, 32'(irq_id), 32'd0);
        chk({tag, " vector"}, vector, 32'd0);
        for (int a = 0; a < 4; a++) begin
            cfg_addr = 2'(a);
            #1;
            chk($sformatf("%s reg%0d", tag, a), cfg_rdata, exp_rd[a]);
        end
    endtask

    initial begin
        // irq, ack, wr, addr, wdata | INTR, irq_id, vector, rdata of addr after the edge
        add('h00,0,1,0,'h01,     0,0,'h000,'h01);
        add('h01,0,0,1,0,        0,0,'h000,'h01);
        add('h01,0,0,3,0,        1,0,'h200,'h10);
        add('h01,1,0,1,0,        0,0,'h200,'h00);
        add('h01,1,0,3,0,        0,0,'h200,'h20);
        add('h00,0,1,3,0,        0,0,'h200,'h00);
        add('h00,0,1,0,'hFF,     0,0,'h200,'hFF);
        add('h24,0,0,1,0,        0,0,'h200,'h24);
        add('h24,0,0,3,0,        1,2,'h208,'h12);
        add('h24,1,0,1,0,        0,2,'h208,'h20);
        add('h24,0,1,3,0,        0,2,'h208,'h02);
        add('h24,0,0,3,0,        1,5,'h214,'h15);
        add('h00,0,1,1,'h20,     1,5,'h214,'h00);
        add('h00,1,0,3,0,        0,5,'h214,'h25);
        add('h00,1,1,3,0,        0,5,'h214,'h05);
        add('h00,0,0,3,0,        0,5,'h214,'h05);
        add('h00,1,0,3,0,        0,5,'h214,'h05);
        add('h00,0,1,0,0,        0,5,'h214,'h00);
        add('h08,0,0,1,0,        0,5,'h214,'h08);
        add('h08,0,0,1,0,        0,5,'h214,'h08);
        add('h08,0,1,0,'h08,     0,5,'h214,'h08);
        add('h08,0,0,3,0,        1,3,'h20C,'h13);
        add('h08,0,1,2,'h1000,   1,3,'h20C,'h1000);
        add('h08,1,0,1,0,        0,3,'h20C,'h00);
        add('h08,0,1,3,0,        0,3,'h20C,'h03);
        add('h0A,0,1,1,'h02,     0,3,'h20C,'h02);
        add('h0A,0,1,1,'h02,     0,3,'h20C,'h00);
        add('h00,0,1,0,'h02,     0,3,'h20C,'h02);
        add('h02,0,0,1,0,        0,3,'h20C,'h02);
        add('h02,0,0,3,0,        1,1,'h1004,'h11);
        add('h00,0,0,1,0,        1,1,'h1004,'h02);
        add('h02,1,0,1,0,        0,1,'h1004,'h02);
        add('h00,0,1,3,0,        0,1,'h1004,'h01);
        add('h00,0,0,3,0,        1,1,'h1004,'h11);

        #12;
        check_reset_regs("por");
        @(negedge sys_clk);
        reset_n = 1'b1;

        foreach (tbl[k]) begin
            irq = tbl[k].irq;  INT_ACK = tbl[k].ack;  cfg_wr = tbl[k].wr;
            cfg_addr = tbl[k].addr;  cfg_wdata = tbl[k].wdata;
            tick();
            chk($sformatf("row%0d INTR", k),   32'(INTR),   32'(tbl[k].e_intr));
            chk($sformatf("row%0d irq_id", k), 32'(irq_id), 32'(tbl[k].e_id));
            chk($sformatf("row%0d vector", k), vector,      tbl[k].e_vec);
            chk($sformatf("row%0d rdata", k),  cfg_rdata,   tbl[k].e_rd);
        end

        // Reset in the middle of REQ must drop INTR with no clock edge.
        cfg_wr = 1'b0;  irq = 8'h01;
        #1;
        chk("pre-reset INTR", 32'(INTR), 32'd1);
        reset_n = 1'b0;
        #1;
        check_reset_regs("midreq");
        @(negedge sys_clk);
        reset_n = 1'b1;
        cfg_addr = 2'd1;
        tick();
        chk("post-reset rise PENDING", cfg_rdata, 32'h01);
        chk("post-reset INTR", 32'(INTR), 32'd0);

        reset_n = 1'b0;  irq = 8'h00;  INT_ACK = 1'b0;
        #2;
        @(negedge sys_clk);
        reset_n = 1'b1;
        model_reset();

        for (int c = 0; c < 3000; c++) begin
            irq = irq ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
            if ($urandom_range(0, 3) == 0) INT_ACK = ~INT_ACK;
            cfg_wr    = ($urandom_range(0, 5) == 0);
            cfg_addr  = 2'($urandom);
            cfg_wdata = $urandom;
            model_edge();
            tick();
            chk($sformatf("rnd%0d INTR", c),   32'(INTR),   32'(m_intr));
            chk($sformatf("rnd%0d irq_id", c), 32'(irq_id), 32'(m_id));
            chk($sformatf("rnd%0d vector", c), vector,      m_vec);
            chk($sformatf("rnd%0d rdata", c),  cfg_rdata,   m_read(cfg_addr));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
